// File: rtl/linebuf_pixgen_pkg.sv
// linebuf_pixgen_pkg: shared FSM encoding, pixel-per-word helpers and RGB channel layout
package linebuf_pixgen_pkg;
  typedef enum logic [1:0] {IDLE, PF0, PF1, ACTIVE} state_t;
  localparam int RGB_N = 3;
  localparam int R_IDX = 2;
  localparam int G_IDX = 1;
  localparam int B_IDX = 0;
  function automatic int pix_per_word(input int word_w, input int bpp);
    return word_w / bpp;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/linebuf_pixgen_palette.sv
// pixgen_palette: 2^BPP x RGB register file, sync write (clk/rst/wr/wr_idx/wr_data), async read (rd_idx -> rd_data)
module pixgen_palette
  import linebuf_pixgen_pkg::*;
#(
  parameter int BPP = 2,
  parameter int COLOR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [BPP-1:0]             wr_idx,
  input  logic [RGB_N*COLOR_W-1:0]   wr_data,
  input  logic [BPP-1:0]             rd_idx,
  output logic [RGB_N*COLOR_W-1:0]   rd_data
);
  localparam int N = 1 << BPP;
  logic [RGB_N*COLOR_W-1:0] mem [N];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= i == N - 1 ? '1 : '0;
    end else if (wr) begin
      mem[wr_idx] <= wr_data;
    end
  end
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/linebuf_pixgen.sv
// linebuf_pixgen: line-buffer prefetch + MSB-first BPP serialiser + palette lookup driving registered red/green/blue, rd_en/rd_addr to the BRAM, sticky underrun
module linebuf_pixgen
  import linebuf_pixgen_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int BPP = 2,
  parameter int ADDR_W = 8,
  parameter int COLOR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_en,
  input  logic                      hvis,
  input  logic                      line_start,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [WORD_W-1:0]         rd_data,
  input  logic                      pal_wr,
  input  logic [BPP-1:0]            pal_idx,
  input  logic [RGB_N*COLOR_W-1:0]  pal_data,
  input  logic [RGB_N*COLOR_W-1:0]  border,
  output logic [COLOR_W-1:0]        red,
  output logic [COLOR_W-1:0]        green,
  output logic [COLOR_W-1:0]        blue,
  output logic                      underrun
);
  localparam int PPW = pix_per_word(WORD_W, BPP);
  localparam int CW = cnt_w(PPW);
  localparam int CLR_W = RGB_N * COLOR_W;
  state_t state;
  logic [WORD_W-1:0] shift_reg, next_word;
  logic [CW-1:0] pix_cnt;
  logic [1:0] nw_pipe;
  logic [CLR_W-1:0] pal_q, col;
  logic ready, vis_pix, adv, word_end;
  assign ready = state == ACTIVE || (state == PF1 && nw_pipe[1]);
  assign vis_pix = pix_en && hvis;
  assign adv = vis_pix && ready;
  assign word_end = adv && pix_cnt == CW'(PPW - 1);
  assign col = !hvis ? '0 : ready ? pal_q : border;
  pixgen_palette #(.BPP(BPP), .COLOR_W(COLOR_W)) u_pal (
    .clk(clk),
    .rst(rst),
    .wr(pal_wr),
    .wr_idx(pal_idx),
    .wr_data(pal_data),
    .rd_idx(shift_reg[WORD_W-1 -: BPP]),
    .rd_data(pal_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_en <= 1'b0;
      rd_addr <= '0;
      underrun <= 1'b0;
      red <= '0;
      green <= '0;
      blue <= '0;
      shift_reg <= '0;
      next_word <= '0;
      pix_cnt <= '0;
      nw_pipe <= '0;
    end else begin
      nw_pipe <= line_start ? 2'b00 : {nw_pipe[0], state == PF0 || word_end};
      if (nw_pipe[1]) next_word <= rd_data;
      if (pix_en) begin
        red <= col[R_IDX*COLOR_W +: COLOR_W];
        green <= col[G_IDX*COLOR_W +: COLOR_W];
        blue <= col[B_IDX*COLOR_W +: COLOR_W];
      end
      if (vis_pix && !ready) underrun <= 1'b1;
      if (adv) begin
        shift_reg <= word_end ? (nw_pipe[1] ? rd_data : next_word) : shift_reg << BPP;
        pix_cnt <= word_end ? '0 : pix_cnt + 1'b1;
      end
      if (word_end) rd_addr <= rd_addr + 1'b1;
      if (line_start) begin
        state <= PF0;
        rd_addr <= '0;
        rd_en <= 1'b1;
        underrun <= 1'b0;
        pix_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          PF0: begin
            rd_addr <= ADDR_W'(1);
            state <= PF1;
          end
          PF1: begin
            if (nw_pipe[1]) state <= ACTIVE;
            else shift_reg <= rd_data;
          end
          ACTIVE: begin
            if (pix_en && !hvis) begin
              state <= IDLE;
              rd_en <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule
